dds_profile_sequencer: RTL and testbench
========================================

Name: dds_profile_sequencer

Overview:
Sequences the stored 184-bit DDS profile words into the AD9910 serializer, one profile per external trigger. Drives sweep_count (profile select into the sorter), starts each serial load, pulses IO_UPDATE after each load completes, and signals end of sweep. Sits between the Rabbit reader (table loaded, sweep_total) and the DDS output shifter, replacing ad-hoc key-driven stepping.

Parameters:
MAX_PROFILES, 12, number of profile slots physically wired (1..31)
UPDATE_PULSE_CYCLES, 4, IO_UPDATE high time in clocks (>=1)
DONE_TIMEOUT, 4096, max clocks waiting for ser_done before error abort

Ports:
ten_MHz_ext  in  1  system clock
key_2_reset  in  1  synchronous reset, active-high
table_valid  in  1  level: reader has loaded the profile table
sweep_total  in  5  number of profiles in the sweep (sampled at start)
start  in  1  one-cycle pulse: begin sweep
step_trigger  in  1  asynchronous external trigger; rising edge advances
abort  in  1  level/pulse: return to idle
ser_ready  in  1  serializer idle and able to accept a load
ser_done  in  1  one-cycle pulse: serial load of current profile finished
ser_start  out  1  one-cycle pulse: load profile sweep_count
sweep_count  out  5  current profile index
io_update  out  1  DDS IO_UPDATE strobe
seq_busy  out  1  high in every state except IDLE
sweep_count_over_flag  out  1  one-cycle pulse: last profile applied
err  out  2  sticky: bit0 config error, bit1 serializer timeout

Behaviour:
- Reset: all outputs 0, state IDLE, trigger synchroniser cleared, latched total 0.
- States: IDLE, LOAD, WAIT_DONE, UPDATE, WAIT_TRIG, DONE.
- IDLE: on start with table_valid=1 and sweep_total!=0: latch total = min(sweep_total, MAX_PROFILES); sweep_count<=0; clear err; go to LOAD. start with sweep_total=0 or table_valid=0: set err[0], stay in IDLE.
- LOAD: when ser_ready=1, ser_start is registered high for exactly one cycle; go to WAIT_DONE. Latency: start high in cycle N -> ser_start high in cycle N+2 if ser_ready is already high.
- WAIT_DONE: ser_done -> UPDATE. Timeout counter reaches DONE_TIMEOUT -> set err[1] and go to IDLE. A ser_done in any other state is ignored.
- UPDATE: io_update high for exactly UPDATE_PULSE_CYCLES cycles, starting the cycle after ser_done. Then: if sweep_count == total-1 -> DONE, else -> WAIT_TRIG.
- WAIT_TRIG: step_trigger passes a 2-FF synchroniser plus an edge register; a rising edge is detected 3 clocks after the pin rises. On detection, sweep_count increments and the block goes to LOAD. Edges outside WAIT_TRIG are dropped, not queued.
- DONE: sweep_count_over_flag high for one cycle, then IDLE; sweep_count holds its last value.
- abort in any state (highest priority, over start, ser_done and trigger): next cycle is IDLE. ser_start and io_update are forced low the same cycle. sweep_count is set to 0. err is unchanged.
- Reset mid-sweep behaves like abort, and also clears err.
- sweep_count changes only on entry to LOAD or on abort/reset, never while ser_start or io_update is high.

Optional Feature:
DDS_SEQ_LOOP_EN:
- Defined: after the last profile's UPDATE, sweep_count wraps to 0 and the block goes to WAIT_TRIG instead of DONE. sweep_count_over_flag pulses one cycle on each wrap. Only abort or reset ends the sweep.
- Undefined: one-shot sweep as described under Behaviour.

Test Plan:
- table_valid=1, sweep_total=3, ser_ready=1, ser_done 5 cycles after each ser_start, 2 triggers -> ser_start with sweep_count 0,1,2; three 4-cycle io_update pulses; over_flag once; seq_busy then 0.
- sweep_total=0 at start -> err=01, seq_busy stays 0, no ser_start.
- sweep_total=20 with MAX_PROFILES=12 -> 12 loads, last sweep_count=11, then over_flag.
- ser_done withheld -> err=10 after 4096 cycles in WAIT_DONE, state IDLE, io_update never asserted.
- Trigger pulses during UPDATE, plus abort asserted in WAIT_TRIG with sweep_count=1 -> extra triggers ignored; after abort sweep_count=0, outputs low next cycle.
- DDS_SEQ_LOOP_EN defined, total=2, 4 triggers -> sweep_count sequence 0,1,0,1,0; over_flag pulses twice; seq_busy remains 1.

Source files
------------

// File: rtl/dds_profile_sequencer_if.sv
// Serializer-side handshake between the DDS profile sequencer and the AD9910 shifter.
interface dds_profile_sequencer_if;
    logic       ser_ready;
    logic       ser_done;
    logic       ser_start;
    logic [4:0] sweep_count;
    logic       io_update;

    modport master (
        input  ser_ready,
        input  ser_done,
        output ser_start,
        output sweep_count,
        output io_update
    );

    modport slave (
        output ser_ready,
        output ser_done,
        input  ser_start,
        input  sweep_count,
        input  io_update
    );
endinterface

// File: rtl/dds_profile_sequencer.sv
// Steps stored DDS profiles into the serializer, one per external trigger, with IO_UPDATE strobes.
// Optional DDS_SEQ_LOOP_EN: continuous looping sweep instead of a one-shot sweep.
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_LOAD      | waiting for ser_ready, then issue ser_start
// ST_WAIT_DONE | waiting for ser_done with timeout
// ST_UPDATE    | io_update high for UPDATE_PULSE_CYCLES
// ST_WAIT_TRIG | waiting for synchronised trigger rising edge
// ST_DONE      | one-cycle end-of-sweep flag
module dds_profile_sequencer #(
    parameter int MAX_PROFILES        = 12,
    parameter int UPDATE_PULSE_CYCLES = 4,
    parameter int DONE_TIMEOUT        = 4096
) (
    input  logic                   ten_MHz_ext,
    input  logic                   key_2_reset,
    input  logic                   table_valid,
    input  logic [4:0]             sweep_total,
    input  logic                   start,
    input  logic                   step_trigger,
    input  logic                   abort,
    dds_profile_sequencer_if.master ser,
    output logic                   seq_busy,
    output logic                   sweep_count_over_flag,
    output logic [1:0]             err
);

    localparam int TMR_MAX = (DONE_TIMEOUT > UPDATE_PULSE_CYCLES) ? DONE_TIMEOUT : UPDATE_PULSE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] TMR_TIMEOUT = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_UPDATE  = TMR_W'(UPDATE_PULSE_CYCLES - 1);
    localparam logic [4:0]       MAX_P       = 5'(MAX_PROFILES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_UPDATE,
        ST_WAIT_TRIG,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       total_q, total_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             ser_start_q, ser_start_d;
    logic             io_update_q, io_update_d;
    logic             over_q, over_d;
    logic [1:0]       err_q, err_d;
    logic             trig_s1_q, trig_s2_q, trig_d_q;
    logic             trig_rise;
    logic             last_profile;

    assign trig_rise    = trig_s2_q & ~trig_d_q;
    assign last_profile = (cnt_q == (total_q - 5'd1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        tmr_d       = tmr_q;
        ser_start_d = 1'b0;
        io_update_d = 1'b0;
        over_d      = 1'b0;
        err_d       = err_q;

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (table_valid && (sweep_total != 5'd0)) begin
                            total_d = (sweep_total > MAX_P) ? MAX_P : sweep_total;
                            cnt_d   = 5'd0;
                            err_d   = 2'b00;
                            state_d = ST_LOAD;
                        end else begin
                            err_d[0] = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ser.ser_ready) begin
                        ser_start_d = 1'b1;
                        tmr_d       = TMR_TIMEOUT;
                        state_d     = ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ser.ser_done) begin
                        io_update_d = 1'b1;
                        tmr_d       = TMR_UPDATE;
                        state_d     = ST_UPDATE;
                    end else if (tmr_q == '0) begin
                        err_d[1] = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (tmr_q != '0) begin
                        io_update_d = 1'b1;
                        tmr_d       = tmr_q - 1'b1;
                    end else if (last_profile) begin
                        over_d = 1'b1;
`ifdef DDS_SEQ_LOOP_EN
                        state_d = ST_WAIT_TRIG;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    // Index advances only on entry to LOAD so it is stable during ser_start/io_update.
                    if (trig_rise) begin
`ifdef DDS_SEQ_LOOP_EN
                        cnt_d = last_profile ? 5'd0 : cnt_q + 5'd1;
`else
                        cnt_d = cnt_q + 5'd1;
`endif
                        state_d = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ten_MHz_ext) begin
        if (key_2_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            total_q     <= 5'd0;
            tmr_q       <= '0;
            ser_start_q <= 1'b0;
            io_update_q <= 1'b0;
            over_q      <= 1'b0;
            err_q       <= 2'b00;
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_d_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            tmr_q       <= tmr_d;
            ser_start_q <= ser_start_d;
            io_update_q <= io_update_d;
            over_q      <= over_d;
            err_q       <= err_d;
            trig_s1_q   <= step_trigger;
            trig_s2_q   <= trig_s1_q;
            trig_d_q    <= trig_s2_q;
        end
    end

    // Abort kills the strobes combinationally so they drop in the same cycle.
    assign ser.ser_start          = ser_start_q & ~abort;
    assign ser.io_update          = io_update_q & ~abort;
    assign ser.sweep_count        = cnt_q;
    assign seq_busy               = (state_q != ST_IDLE);
    assign sweep_count_over_flag  = over_q;
    assign err                    = err_q;

endmodule

// File: tb/tb_dds_profile_sequencer.sv
// Scoreboard bench for dds_profile_sequencer: expected load indices queued at start, checked on ser_start.
module tb_dds_profile_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       table_valid = 1'b0;
    logic [4:0] sweep_total = 5'd0;
    logic       start = 1'b0;
    logic       step_trigger = 1'b0;
    logic       abort = 1'b0;
    logic       seq_busy;
    logic       over_flag;
    logic [1:0] err;

    dds_profile_sequencer_if ser_if ();

    dds_profile_sequencer dut (
        .ten_MHz_ext           (clk),
        .key_2_reset           (rst),
        .table_valid           (table_valid),
        .sweep_total           (sweep_total),
        .start                 (start),
        .step_trigger          (step_trigger),
        .abort                 (abort),
        .ser                   (ser_if),
        .seq_busy              (seq_busy),
        .sweep_count_over_flag (over_flag),
        .err                   (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ser   = 0;
    int n_upd   = 0;
    int n_over  = 0;
    int upd_len = 0;
    bit upd_chk = 1'b1;
    bit done_en = 1'b1;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (ser_if.ser_start) begin
            n_ser++;
            if (exp_q.size() == 0) check("unexpected_load", 1, 0);
            else check("load_index", ser_if.sweep_count, exp_q.pop_front());
        end
        if (ser_if.io_update) begin
            upd_len++;
        end else if (upd_len != 0) begin
            if (upd_chk) check("io_update_len", upd_len, 4);
            n_upd++;
            upd_len = 0;
        end
        if (over_flag) n_over++;
    end

    // Serializer model: ser_done five cycles after each ser_start
    initial begin
        ser_if.ser_ready = 1'b1;
        ser_if.ser_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (ser_if.ser_start && done_en) begin
                repeat (5) @(posedge clk);
                #1 ser_if.ser_done = 1'b1;
                @(posedge clk);
                #1 ser_if.ser_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] tot, input logic tv);
        @(posedge clk); #1 table_valid = tv; sweep_total = tot; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_trig();
        @(posedge clk); #1 step_trigger = 1'b1;
        repeat (3) @(posedge clk);
        #1 step_trigger = 1'b0;
    endtask

    task automatic wait_upd(input int target);
        int k = 0;
        while (n_upd < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("update_wait", (n_upd >= target), 1);
    endtask

    task automatic do_trig(input int upd_target);
        wait_upd(upd_target);
        repeat (3) @(posedge clk);
        pulse_trig();
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (seq_busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, seq_busy, 0);
    endtask

    task automatic wait_io_update();
        int k = 0;
        while (!ser_if.io_update && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("io_update_seen", ser_if.io_update, 1);
    endtask

    int b_ser, b_upd, b_over, cyc;

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_busy", seq_busy, 0);
        check("rst_ser_start", ser_if.ser_start, 0);
        check("rst_io_update", ser_if.io_update, 0);
        check("rst_sweep_count", ser_if.sweep_count, 0);
        check("rst_over", over_flag, 0);
        check("rst_err", err, 0);

`ifdef DDS_SEQ_LOOP_EN
        // Looping sweep of two profiles, four triggers
        b_ser = n_ser; b_upd = n_upd; b_over = n_over;
        exp_q.push_back(5'd0); exp_q.push_back(5'd1); exp_q.push_back(5'd0);
        exp_q.push_back(5'd1); exp_q.push_back(5'd0);
        do_start(5'd2, 1'b1);
        for (int i = 1; i <= 4; i++) do_trig(b_upd + i);
        wait_upd(b_upd + 5);
        repeat (10) @(negedge clk);
        check("loop_loads", n_ser - b_ser, 5);
        check("loop_over", n_over - b_over, 2);
        check("loop_busy", seq_busy, 1);
        check("loop_queue", exp_q.size(), 0);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("loop_abort_idle", seq_busy, 0);
`else
        // Basic three-profile sweep with start latency check
        b_ser = n_ser; b_upd = n_upd; b_over = n_over;
        for (int i = 0; i < 3; i++) exp_q.push_back(5'(i));
        do_start(5'd3, 1'b1);
        @(negedge clk);
        check("lat_n1_ser_start", ser_if.ser_start, 0);
        check("lat_n1_busy", seq_busy, 1);
        @(negedge clk);
        check("lat_n2_ser_start", ser_if.ser_start, 1);
        do_trig(b_upd + 1);
        do_trig(b_upd + 2);
        wait_idle("sweep3_idle");
        check("sweep3_loads", n_ser - b_ser, 3);
        check("sweep3_updates", n_upd - b_upd, 3);
        check("sweep3_over", n_over - b_over, 1);
        check("sweep3_last_count", ser_if.sweep_count, 2);
        check("sweep3_err", err, 0);
        check("sweep3_queue", exp_q.size(), 0);

        // Total clamped to MAX_PROFILES
        b_ser = n_ser; b_upd = n_upd; b_over = n_over;
        for (int i = 0; i < 12; i++) exp_q.push_back(5'(i));
        do_start(5'd20, 1'b1);
        for (int i = 1; i <= 11; i++) do_trig(b_upd + i);
        wait_idle("sweep20_idle");
        check("sweep20_loads", n_ser - b_ser, 12);
        check("sweep20_last_count", ser_if.sweep_count, 11);
        check("sweep20_over", n_over - b_over, 1);
        check("sweep20_queue", exp_q.size(), 0);
`endif

        // Configuration errors
        do_reset();
        b_ser = n_ser;
        do_start(5'd0, 1'b1);
        repeat (5) @(negedge clk);
        check("total0_err", err, 1);
        check("total0_busy", seq_busy, 0);
        check("total0_no_load", n_ser - b_ser, 0);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_keeps_err", err, 1);
        do_reset();
        @(negedge clk);
        check("reset_clears_err", err, 0);
        do_start(5'd3, 1'b0);
        repeat (5) @(negedge clk);
        check("novalid_err", err, 1);
        check("novalid_busy", seq_busy, 0);
        check("novalid_no_load", n_ser - b_ser, 0);

        // Serializer timeout
        done_en = 1'b0;
        b_upd = n_upd;
        exp_q.push_back(5'd0);
        do_start(5'd3, 1'b1);
        cyc = 0;
        while (!ser_if.ser_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_ser_start", ser_if.ser_start, 1);
        cyc = 0;
        while (seq_busy && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, 4096);
        check("timeout_err", err, 2);
        check("timeout_busy", seq_busy, 0);
        check("timeout_no_update", n_upd - b_upd, 0);
        done_en = 1'b1;

        // Triggers during UPDATE are dropped; abort in WAIT_TRIG
        b_ser = n_ser; b_upd = n_upd;
        exp_q.push_back(5'd0); exp_q.push_back(5'd1);
        do_start(5'd3, 1'b1);
        wait_io_update();
        pulse_trig();
        repeat (20) @(negedge clk);
        check("upd_trig_dropped", n_ser - b_ser, 1);
        check("upd_trig_busy", seq_busy, 1);
        check("start_clears_err", err, 0);
        pulse_trig();
        wait_upd(b_upd + 2);
        repeat (5) @(negedge clk);
        check("pre_abort_count", ser_if.sweep_count, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", seq_busy, 0);
        check("abort_count", ser_if.sweep_count, 0);
        check("abort_ser_start", ser_if.ser_start, 0);
        check("abort_io_update", ser_if.io_update, 0);
        check("abort_queue", exp_q.size(), 0);

        // Abort while io_update is high forces it low in the same cycle
        exp_q.push_back(5'd0);
        do_start(5'd3, 1'b1);
        wait_io_update();
        upd_chk = 1'b0;
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        check("abort_upd_same_cycle", ser_if.io_update, 0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_upd_idle", seq_busy, 0);
        check("abort_upd_count", ser_if.sweep_count, 0);
        repeat (3) @(negedge clk);
        upd_chk = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
